ccff_bitstream_loader: RTL and testbench

//  Configuration-chain driver upstream of the grid tiles. Accepts bitstream

---
 rtl/ccff_bitstream_loader.sv | 122 ++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: takes bitstream words on a valid/ready port and
// shifts them LSB first onto ccff_head, enabling the chain clock only for valid bits.
module ccff_bitstream_loader #(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = 64,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              PROG_RESET_N,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              prog_clk_en,
   output logic              IO_ISOL_N,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        fsm_state
);

   localparam int REM_W = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] WORD_W_C    = CNT_W'(WORD_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state;
   logic [WORD_W-1:0] shift_reg;
   logic [REM_W-1:0]  bits_left;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  committed;
   logic [CNT_W-1:0]  room;
   logic [CNT_W-1:0]  take;
   logic              accept;

   // Handshake: a word transfers at a rising edge where cfg_valid && cfg_ready.
   // cfg_ready is offered while the shift register is empty or on its last bit,
   // the chain still has room, and no abort is pending, so an aborting cycle
   // never swallows a word.
   assign room      = CHAIN_LEN_C - committed;
   assign take      = (room < WORD_W_C) ? room : WORD_W_C;
   assign cfg_ready = (state == ST_LOAD) && !abort && (bits_left == '0) &&
                      (committed < CHAIN_LEN_C);
   assign accept    = cfg_valid && cfg_ready;
   assign fsm_state = state;

   always_ff @(posedge prog_clk or negedge PROG_RESET_N) begin
      if (!PROG_RESET_N) begin
         state       <= ST_IDLE;
         shift_reg   <= '0;
         bits_left   <= '0;
         bit_cnt     <= '0;
         committed   <= '0;
         ccff_head   <= 1'b0;
         prog_clk_en <= 1'b0;
         IO_ISOL_N   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_LOAD;
                  bit_cnt   <= '0;
                  committed <= '0;
                  shift_reg <= '0;
                  bits_left <= '0;
                  err       <= 1'b0;
                  IO_ISOL_N <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  state       <= ST_IDLE;
                  prog_clk_en <= 1'b0;
                  busy        <= 1'b0;
                  err         <= 1'b1;
                  IO_ISOL_N   <= 1'b0;
                  bits_left   <= '0;
                  shift_reg   <= '0;
               end else if (accept) begin
                  // Only the bits that still fit in the chain are scheduled.
                  ccff_head   <= cfg_data[0];
                  shift_reg   <= cfg_data >> 1;
                  bits_left   <= REM_W'(take - CNT_W'(1));
                  committed   <= committed + take;
                  bit_cnt     <= bit_cnt + CNT_W'(1);
                  prog_clk_en <= 1'b1;
               end else if (bits_left != '0) begin
                  ccff_head   <= shift_reg[0];
                  shift_reg   <= shift_reg >> 1;
                  bits_left   <= bits_left - REM_W'(1);
                  bit_cnt     <= bit_cnt + CNT_W'(1);
                  prog_clk_en <= 1'b1;
               end else if (bit_cnt == CHAIN_LEN_C) begin
                  state       <= ST_DONE;
                  prog_clk_en <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  IO_ISOL_N   <= 1'b1;
               end else begin
                  // Input stall: chain frozen, ccff_head holds.
                  prog_clk_en <= 1'b0;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two instances (64-bit and 40-bit chains) driven
// with fixed and random bitstreams, compared against a bit-queue reference model.
module tb_ccff_bitstream_loader;

   localparam int LEN0 = 64;
   localparam int LEN1 = 40;

   logic        clk;
   logic        rst_n;
   logic [1:0]  start_s;
   logic [1:0]  abort_s;
   logic [1:0]  valid_s;
   logic [31:0] data_s [2];
   logic [1:0]  rdy, head, en, iso, bsy, dn, er;
   logic [1:0]  st0, st1;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] wq[$];
   logic [0:0]  exp_q[$];

   ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(LEN0), .CNT_W(16)) dut0 (
      .prog_clk(clk), .PROG_RESET_N(rst_n), .start(start_s[0]), .abort(abort_s[0]),
      .cfg_data(data_s[0]), .cfg_valid(valid_s[0]), .cfg_ready(rdy[0]),
      .ccff_head(head[0]), .prog_clk_en(en[0]), .IO_ISOL_N(iso[0]), .busy(bsy[0]),
      .done(dn[0]), .err(er[0]), .fsm_state(st0)
   );

   ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(LEN1), .CNT_W(16)) dut1 (
      .prog_clk(clk), .PROG_RESET_N(rst_n), .start(start_s[1]), .abort(abort_s[1]),
      .cfg_data(data_s[1]), .cfg_valid(valid_s[1]), .cfg_ready(rdy[1]),
      .ccff_head(head[1]), .prog_clk_en(en[1]), .IO_ISOL_N(iso[1]), .busy(bsy[1]),
      .done(dn[1]), .err(er[1]), .fsm_state(st1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] out_vec(input int d);
      return {rdy[d], head[d], en[d], iso[d], bsy[d], dn[d], er[d]};
   endfunction

   function automatic int chain_len(input int d);
      return (d == 0) ? LEN0 : LEN1;
   endfunction

   task automatic fill_random(input int d);
      wq.delete();
      for (int i = 0; i < (chain_len(d) + 31) / 32; i++) wq.push_back($urandom);
   endtask

   // Runs one load on instance d using the words in wq. stall_len: cycles valid is
   // withheld once the first word drains; abort_at: abort after that many bits
   // (negative = never); poke: pulse start mid-load and in the DONE cycle.
   task automatic run_load(input int d, input int stall_len, input int abort_at, input bit poke);
      int len, bits_seen, cyc, first_en, last_en, acc, stall_cnt;
      bit fin, got_done, chk_rdy, abort_next, start_next, aborted;
      len = chain_len(d);
      exp_q.delete();
      foreach (wq[w])
         for (int b = 0; b < 32; b++)
            if (exp_q.size() < len) exp_q.push_back(wq[w][b]);
      bits_seen = 0; cyc = 0; first_en = -1; last_en = -1; acc = 0; stall_cnt = 0;
      fin = 0; got_done = 0; chk_rdy = 0; abort_next = 0; start_next = 0; aborted = 0;

      @(posedge clk); #1 start_s[d] = 1'b1;
      @(posedge clk); #1 start_s[d] = 1'b0;
      while (!fin && cyc < 400) begin
         abort_s[d] = abort_next;
         start_s[d] = start_next;
         valid_s[d] = (wq.size() > 0) && !abort_next && !(acc == 1 && stall_cnt < stall_len);
         data_s[d]  = (wq.size() > 0) ? wq[0] : 32'h0;
         abort_next = 1'b0;
         start_next = 1'b0;
         @(negedge clk);
         if (cyc == 0) begin
            check_eq("busy_after_start", bsy[d], 1);
            check_eq("err_cleared_by_start", er[d], 0);
            check_eq("iso_low_in_load", iso[d], 0);
            check_eq("ready_first_cycle", rdy[d], 1);
         end
         if (chk_rdy) begin
            check_eq("ready_low_after_final_word", rdy[d], 0);
            chk_rdy = 1'b0;
         end
         if (aborted) begin
            check_eq("abort_en", en[d], 0);
            check_eq("abort_err", er[d], 1);
            check_eq("abort_iso", iso[d], 0);
            check_eq("abort_busy", bsy[d], 0);
            check_eq("abort_ready", rdy[d], 0);
            fin = 1'b1;
         end else begin
            if (abort_s[d]) aborted = 1'b1;
            if (en[d]) begin
               if (exp_q.size() == 0) check_eq("extra_bit", 1, 0);
               else check_eq("bit", head[d], exp_q.pop_front());
               bits_seen++;
               if (first_en < 0) first_en = cyc;
               last_en = cyc;
               if (bits_seen == abort_at) abort_next = 1'b1;
               if (poke && (bits_seen == 10 || bits_seen == len)) start_next = 1'b1;
               if (bits_seen == len) check_eq("iso_low_before_done", iso[d], 0);
            end
            if (valid_s[d] && rdy[d]) begin
               void'(wq.pop_front());
               acc++;
               if (wq.size() == 0) chk_rdy = 1'b1;
            end else if (acc == 1 && !valid_s[d] && rdy[d]) begin
               stall_cnt++;
            end
            if (dn[d]) begin
               check_eq("done_after_last_bit", cyc - last_en, 1);
               check_eq("iso_with_done", iso[d], 1);
               check_eq("busy_at_done", bsy[d], 0);
               check_eq("en_at_done", en[d], 0);
               check_eq("bit_count", bits_seen, len);
               check_eq("bits_left_in_model", exp_q.size(), 0);
               check_eq("first_bit_latency", first_en, 1);
               check_eq("en_gap", last_en - first_en + 1 - len, stall_len);
               fin = 1'b1;
               got_done = 1'b1;
            end
         end
         cyc++;
         if (!fin) begin
            @(posedge clk); #1;
         end
      end
      if (!fin) check_eq("load_timeout", cyc, 0);
      @(posedge clk); #1;
      start_s[d] = 1'b0; abort_s[d] = 1'b0; valid_s[d] = 1'b0;
      if (got_done) begin
         @(negedge clk);
         check_eq("done_one_cycle", dn[d], 0);
         check_eq("idle_after_done_busy", bsy[d], 0);
         check_eq("iso_held_after_done", iso[d], 1);
      end
   endtask

   initial begin
      rst_n = 1'b0; start_s = '0; abort_s = '0; valid_s = '0;
      data_s[0] = '0; data_s[1] = '0;
      #2;
      check_eq("reset_outputs_dut0", out_vec(0), 0);
      check_eq("reset_outputs_dut1", out_vec(1), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      wq = '{32'hA5A5_0F0F, 32'h1234_5678};
      run_load(0, 0, -1, 1'b0);

      wq = '{32'hFFFF_FFFF, 32'h0000_00AB};
      run_load(1, 0, -1, 1'b0);

      wq = '{32'hA5A5_0F0F, 32'h1234_5678};
      run_load(0, 5, -1, 1'b0);

      fill_random(0);
      run_load(0, 0, 21, 1'b0);
      fill_random(0);
      run_load(0, 0, -1, 1'b0);

      fill_random(0);
      run_load(0, 2, -1, 1'b1);

      for (int i = 0; i < 8; i++) begin
         int d;
         int ab;
         d = $urandom_range(1, 0);
         ab = ($urandom_range(3, 0) == 0) ? $urandom_range(chain_len(d) - 1, 1) : -1;
         fill_random(d);
         run_load(d, $urandom_range(6, 0), ab, 1'(($urandom_range(1, 0))));
      end

      // Reset asserted between edges in the middle of a load.
      fill_random(0);
      @(posedge clk); #1 start_s[0] = 1'b1;
      @(posedge clk); #1 start_s[0] = 1'b0; valid_s[0] = 1'b1; data_s[0] = wq[0];
      repeat (10) @(posedge clk);
      #3;
      check_eq("en_before_reset", en[0], 1);
      rst_n = 1'b0;
      #1;
      check_eq("midcycle_reset_dut0", out_vec(0), 0);
      check_eq("midcycle_reset_dut1", out_vec(1), 0);
      valid_s[0] = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;

      fill_random(0);
      run_load(0, 0, -1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
